// File: rtl/jpeg_mcu_interleaver.sv
// Per-channel entropy symbol FIFOs merged into one MCU-ordered stream.
// Luma (channel 0) contributes Y_BLOCKS blocks per MCU, every other channel one block.
module jpeg_mcu_interleaver #(
  parameter int CHANNELS   = 3,
  parameter int VLI_WIDTH  = 9,
  parameter int FIFO_DEPTH = 64,
  parameter int Y_BLOCKS   = 1,
  parameter int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [VLI_WIDTH-1:0] in_vli   [CHANNELS],
  input  logic [3:0]           in_size  [CHANNELS],
  input  logic [3:0]           in_run   [CHANNELS],
  input  logic                 in_isDC  [CHANNELS],
  input  logic                 in_eob   [CHANNELS],
  input  logic                 in_valid [CHANNELS],
  output logic                 in_ready [CHANNELS],
  output logic [VLI_WIDTH-1:0] out_vli,
  output logic [3:0]           out_size,
  output logic [3:0]           out_run,
  output logic                 out_isDC,
  output logic                 out_eob,
  output logic [CW-1:0]        out_chan,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          mcu_count,
  output logic                 busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = VLI_WIDTH + 10;
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CHAN  = CW'(CHANNELS - 1);
  localparam logic [1:0]    LAST_YBLK  = 2'(Y_BLOCKS - 1);

  logic [SW-1:0] mem_q   [CHANNELS][FIFO_DEPTH];
  logic [AW-1:0] wptr_q  [CHANNELS];
  logic [AW-1:0] wptr_d  [CHANNELS];
  logic [AW-1:0] rptr_q  [CHANNELS];
  logic [AW-1:0] rptr_d  [CHANNELS];
  logic [AW:0]   count_q [CHANNELS];
  logic [AW:0]   count_d [CHANNELS];
  logic          push    [CHANNELS];
  logic          pop     [CHANNELS];
  logic [SW-1:0] wr_sym  [CHANNELS];

  logic [SW-1:0] head_sym;
  logic          head_ok;
  logic          load_en;
  logic [SW-1:0] out_sym_q, out_sym_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_chan_q, out_chan_d;
  logic [CW-1:0] cur_chan_q, cur_chan_d;
  logic [1:0]    blk_idx_q, blk_idx_d;
  logic [15:0]   mcu_count_q, mcu_count_d;

  // A full FIFO refuses a push even if it is popped on the same edge.
  always_comb begin
    load_en  = !out_valid_q || out_ready;
    head_ok  = (count_q[cur_chan_q] != '0);
    head_sym = mem_q[cur_chan_q][rptr_q[cur_chan_q]];
    busy     = out_valid_q;
    for (int c = 0; c < CHANNELS; c++) begin
      in_ready[c] = (count_q[c] != FULL_COUNT);
      push[c]     = in_valid[c] && in_ready[c];
      pop[c]      = load_en && head_ok && (cur_chan_q == CW'(c));
      wr_sym[c]   = {in_vli[c], in_size[c], in_run[c], in_isDC[c], in_eob[c]};
      wptr_d[c]   = push[c] ? wptr_q[c] + AW'(1) : wptr_q[c];
      rptr_d[c]   = pop[c]  ? rptr_q[c] + AW'(1) : rptr_q[c];
      count_d[c]  = count_q[c] + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
      if (count_q[c] != '0) busy = 1'b1;
    end
  end

  always_comb begin
    out_sym_d   = out_sym_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    cur_chan_d  = cur_chan_q;
    blk_idx_d   = blk_idx_q;
    mcu_count_d = mcu_count_q;
    if (load_en) begin
      if (head_ok) begin
        out_valid_d = 1'b1;
        out_sym_d   = head_sym;
        out_chan_d  = cur_chan_q;
        // The end-of-block symbol moves the schedule on as it is loaded.
        if (head_sym[0]) begin
          if (cur_chan_q == '0 && blk_idx_q != LAST_YBLK) begin
            blk_idx_d = blk_idx_q + 2'd1;
          end else begin
            blk_idx_d = '0;
            if (cur_chan_q == LAST_CHAN) begin
              cur_chan_d  = '0;
              mcu_count_d = mcu_count_q + 16'd1;
            end else begin
              cur_chan_d = cur_chan_q + CW'(1);
            end
          end
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push[c]) mem_q[c][wptr_q[c]] <= wr_sym[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
        count_q[c] <= '0;
      end
      out_sym_q   <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      cur_chan_q  <= '0;
      blk_idx_q   <= '0;
      mcu_count_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr_q[c]  <= wptr_d[c];
        rptr_q[c]  <= rptr_d[c];
        count_q[c] <= count_d[c];
      end
      out_sym_q   <= out_sym_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      cur_chan_q  <= cur_chan_d;
      blk_idx_q   <= blk_idx_d;
      mcu_count_q <= mcu_count_d;
    end
  end

  assign out_vli   = out_sym_q[SW-1:10];
  assign out_size  = out_sym_q[9:6];
  assign out_run   = out_sym_q[5:2];
  assign out_isDC  = out_sym_q[1];
  assign out_eob   = out_sym_q[0];
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign mcu_count = mcu_count_q;

endmodule

// File: tb/tb_jpeg_mcu_interleaver.sv
// Bench for jpeg_mcu_interleaver: 4:4:4 and 4:2:0 instances share stimulus and are each
// tracked by a queue-based reference model; a single-channel instance covers the MCU counter wrap.
module tb_jpeg_mcu_interleaver;
  typedef logic [18:0] sym_t;
  typedef struct packed {
    logic [2:0]  vmask;
    sym_t        sym;
    logic        ordy;
    logic        ev;
    logic [1:0]  ec;
    logic        ee;
    logic [15:0] em;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [8:0] in_vli   [3];
  logic [3:0] in_size  [3];
  logic [3:0] in_run   [3];
  logic       in_isDC  [3];
  logic       in_eob   [3];
  logic       in_valid [3];
  logic       out_ready;

  logic ir1 [3];
  logic [8:0] o1_vli; logic [3:0] o1_size, o1_run; logic o1_isdc, o1_eob, o1_valid, o1_busy;
  logic [1:0] o1_chan; logic [15:0] o1_mcu;
  logic ir4 [3];
  logic [8:0] o4_vli; logic [3:0] o4_size, o4_run; logic o4_isdc, o4_eob, o4_valid, o4_busy;
  logic [1:0] o4_chan; logic [15:0] o4_mcu;

  logic [8:0] w_vli [1]; logic [3:0] w_size [1]; logic [3:0] w_run [1];
  logic w_isdc [1]; logic w_eob [1]; logic w_valid [1]; logic w_ir [1];
  logic [8:0] wo_vli; logic [3:0] wo_size, wo_run; logic wo_isdc, wo_eob, wo_valid, wo_busy, wo_chan;
  logic [15:0] w_mcu; logic w_ordy;

  jpeg_mcu_interleaver #(.CHANNELS(3), .VLI_WIDTH(9), .FIFO_DEPTH(64), .Y_BLOCKS(1)) u_dut1 (
    .clk(clk), .rst_n(rst), .in_vli(in_vli), .in_size(in_size), .in_run(in_run),
    .in_isDC(in_isDC), .in_eob(in_eob), .in_valid(in_valid), .in_ready(ir1),
    .out_vli(o1_vli), .out_size(o1_size), .out_run(o1_run), .out_isDC(o1_isdc),
    .out_eob(o1_eob), .out_chan(o1_chan), .out_valid(o1_valid), .out_ready(out_ready),
    .mcu_count(o1_mcu), .busy(o1_busy));

  jpeg_mcu_interleaver #(.CHANNELS(3), .VLI_WIDTH(9), .FIFO_DEPTH(64), .Y_BLOCKS(4)) u_dut4 (
    .clk(clk), .rst_n(rst), .in_vli(in_vli), .in_size(in_size), .in_run(in_run),
    .in_isDC(in_isDC), .in_eob(in_eob), .in_valid(in_valid), .in_ready(ir4),
    .out_vli(o4_vli), .out_size(o4_size), .out_run(o4_run), .out_isDC(o4_isdc),
    .out_eob(o4_eob), .out_chan(o4_chan), .out_valid(o4_valid), .out_ready(out_ready),
    .mcu_count(o4_mcu), .busy(o4_busy));

  jpeg_mcu_interleaver #(.CHANNELS(1), .VLI_WIDTH(9), .FIFO_DEPTH(64), .Y_BLOCKS(1)) u_dutw (
    .clk(clk), .rst_n(rst), .in_vli(w_vli), .in_size(w_size), .in_run(w_run),
    .in_isDC(w_isdc), .in_eob(w_eob), .in_valid(w_valid), .in_ready(w_ir),
    .out_vli(wo_vli), .out_size(wo_size), .out_run(wo_run), .out_isDC(wo_isdc),
    .out_eob(wo_eob), .out_chan(wo_chan), .out_valid(wo_valid), .out_ready(w_ordy),
    .mcu_count(w_mcu), .busy(wo_busy));

  int total = 0;
  int bad   = 0;

  // Reference model: one symbol queue per (instance, channel) plus the output register.
  sym_t mq [6][$];
  logic mov [2];
  sym_t msym [2];
  int   mchan [2];
  int   mcc [2];
  int   mbi [2];
  int   mmcu [2];

  function automatic sym_t mkSym(input logic [8:0] v, input logic [3:0] s, input logic [3:0] r,
                                 input logic dc, input logic e);
    return {v, s, r, dc, e};
  endfunction

  task automatic modelStep();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int c = 0; c < 3; c++) mq[d*3+c].delete();
        mov[d] = 1'b0; msym[d] = '0; mchan[d] = 0; mcc[d] = 0; mbi[d] = 0; mmcu[d] = 0;
      end else begin
        logic acc [3];
        sym_t h;
        int   yb;
        yb = (d == 0) ? 1 : 4;
        for (int c = 0; c < 3; c++) acc[c] = in_valid[c] && (mq[d*3+c].size() < 64);
        if (!mov[d] || out_ready) begin
          if (mq[d*3+mcc[d]].size() > 0) begin
            h = mq[d*3+mcc[d]].pop_front();
            mov[d] = 1'b1; msym[d] = h; mchan[d] = mcc[d];
            if (h[0]) begin
              if (mcc[d] == 0 && mbi[d] < yb - 1) mbi[d]++;
              else begin
                mbi[d] = 0;
                mcc[d] = (mcc[d] + 1) % 3;
                if (mcc[d] == 0) mmcu[d] = (mmcu[d] + 1) % 65536;
              end
            end
          end else mov[d] = 1'b0;
        end
        for (int c = 0; c < 3; c++)
          if (acc[c]) mq[d*3+c].push_back({in_vli[c], in_size[c], in_run[c], in_isDC[c], in_eob[c]});
      end
    end
  endtask

  function automatic logic [41:0] expVec(input int d);
    logic       b;
    logic [2:0] rdy;
    b = mov[d];
    for (int c = 0; c < 3; c++) begin
      if (mq[d*3+c].size() > 0) b = 1'b1;
      rdy[c] = (mq[d*3+c].size() < 64);
    end
    return {mov[d], mov[d] ? msym[d] : 19'd0, mov[d] ? 2'(mchan[d]) : 2'd0, 16'(mmcu[d]), b, rdy};
  endfunction

  function automatic logic [41:0] actVec(input int d);
    if (d == 0)
      return {o1_valid, o1_valid ? {o1_vli, o1_size, o1_run, o1_isdc, o1_eob} : 19'd0,
              o1_valid ? o1_chan : 2'd0, o1_mcu, o1_busy, ir1[2], ir1[1], ir1[0]};
    return {o4_valid, o4_valid ? {o4_vli, o4_size, o4_run, o4_isdc, o4_eob} : 19'd0,
            o4_valid ? o4_chan : 2'd0, o4_mcu, o4_busy, ir4[2], ir4[1], ir4[0]};
  endfunction

  task automatic checkVal(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic checkOutput();
    for (int d = 0; d < 2; d++)
      checkVal($sformatf("model_y%0d", (d == 0) ? 1 : 4), 64'(actVec(d)), 64'(expVec(d)));
  endtask

  task automatic applyStimulus(input logic [2:0] vmask, input sym_t s0, input sym_t s1,
                               input sym_t s2, input logic ordy);
    sym_t s [3];
    s[0] = s0; s[1] = s1; s[2] = s2;
    for (int c = 0; c < 3; c++) begin
      in_valid[c] = vmask[c];
      in_vli[c]   = s[c][18:10];
      in_size[c]  = s[c][9:6];
      in_run[c]   = s[c][5:2];
      in_isDC[c]  = s[c][1];
      in_eob[c]   = s[c][0];
    end
    out_ready = ordy;
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(3'b000, '0, '0, '0, 1'b1);
    tick();
    rst = 1'b0;
  endtask

  task automatic checkReset(input string name);
    checkVal({name, "_y1"}, {o1_valid, o1_vli, o1_size, o1_run, o1_isdc, o1_eob, o1_chan, o1_mcu,
                             o1_busy, ir1[2], ir1[1], ir1[0]}, 64'd7);
    checkVal({name, "_y4"}, {o4_valid, o4_vli, o4_size, o4_run, o4_isdc, o4_eob, o4_chan, o4_mcu,
                             o4_busy, ir4[2], ir4[1], ir4[0]}, 64'd7);
  endtask

  initial begin
    vec_t t1 [8];
    sym_t dcS, eobS, bpS, s65, rs [3];
    int   seq [$];
    int   outs, n2, expc;
    logic seenPop, gotReady;

    dcS  = mkSym(9'd5, 4'd3, 4'd0, 1'b1, 1'b0);
    eobS = mkSym(9'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    w_vli[0] = 9'd7; w_size[0] = 4'd3; w_run[0] = 4'd0; w_isdc[0] = 1'b1; w_eob[0] = 1'b1;
    w_valid[0] = 1'b0; w_ordy = 1'b1;

    doReset();
    checkReset("reset");

    // 4:4:4, all channels deliver DC then EOB together.
    t1[0] = '{3'b111, dcS,  1'b1, 1'b0, 2'd0, 1'b0, 16'd0};
    t1[1] = '{3'b111, eobS, 1'b1, 1'b1, 2'd0, 1'b0, 16'd0};
    t1[2] = '{3'b000, '0,   1'b1, 1'b1, 2'd0, 1'b1, 16'd0};
    t1[3] = '{3'b000, '0,   1'b1, 1'b1, 2'd1, 1'b0, 16'd0};
    t1[4] = '{3'b000, '0,   1'b1, 1'b1, 2'd1, 1'b1, 16'd0};
    t1[5] = '{3'b000, '0,   1'b1, 1'b1, 2'd2, 1'b0, 16'd0};
    t1[6] = '{3'b000, '0,   1'b1, 1'b1, 2'd2, 1'b1, 16'd1};
    t1[7] = '{3'b000, '0,   1'b1, 1'b0, 2'd0, 1'b0, 16'd1};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(t1[i].vmask, t1[i].sym, t1[i].sym, t1[i].sym, t1[i].ordy);
      tick();
      checkVal($sformatf("t1_row%0d", i),
               {o1_valid, o1_valid ? o1_chan : 2'd0, o1_valid ? o1_eob : 1'b0, o1_mcu},
               {t1[i].ev, t1[i].ec, t1[i].ee, t1[i].em});
    end

    // 4:2:0: chroma arrives first, luma later.
    doReset();
    applyStimulus(3'b110, '0, dcS, dcS, 1'b1);   tick();
    applyStimulus(3'b110, '0, eobS, eobS, 1'b1); tick();
    applyStimulus(3'b000, '0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkVal("t2_wait_luma", o4_valid, 0);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'b001, (i % 2 == 0) ? dcS : eobS, '0, '0, 1'b1);
      tick();
      if (o4_valid) seq.push_back(int'(o4_chan));
    end
    applyStimulus(3'b000, '0, '0, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o4_valid) seq.push_back(int'(o4_chan));
    end
    checkVal("t2_len", seq.size(), 12);
    for (int i = 0; i < 12; i++) begin
      expc = (i < 8) ? 0 : (i < 10) ? 1 : 2;
      checkVal($sformatf("t2_chan%0d", i), (i < seq.size()) ? seq[i] : 99, expc);
    end
    checkVal("t2_mcu", o4_mcu, 1);

    // Backpressure holds the output register.
    doReset();
    bpS = mkSym(9'h1A4, 4'd9, 4'd3, 1'b0, 1'b0);
    applyStimulus(3'b001, bpS, '0, '0, 1'b0);  tick();
    applyStimulus(3'b001, eobS, '0, '0, 1'b0); tick();
    checkVal("t3_loaded", {o1_valid, o1_vli, o1_size, o1_run, o1_eob}, {1'b1, 9'h1A4, 4'd9, 4'd3, 1'b0});
    applyStimulus(3'b000, '0, '0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkVal("t3_hold", {o1_valid, o1_vli, o1_size, o1_run}, {1'b1, 9'h1A4, 4'd9, 4'd3});
    end
    applyStimulus(3'b000, '0, '0, '0, 1'b1); tick();
    checkVal("t3_next_eob", {o1_valid, o1_eob}, 2'b11);
    tick();
    checkVal("t3_bubble", o1_valid, 0);

    // Fill channel 2 while the scheduler waits on luma.
    doReset();
    for (int i = 0; i < 64; i++) begin
      applyStimulus(3'b100, '0, '0, mkSym(9'($urandom), 4'($urandom), 4'($urandom), 1'b0, 1'b0), 1'b1);
      tick();
      if (i == 62) checkVal("t4_ready_63", ir1[2], 1);
    end
    checkVal("t4_full", ir1[2], 0);
    s65 = mkSym(9'h0AB, 4'd8, 4'd1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(3'b100, '0, '0, s65, 1'b1); tick();
      checkVal("t4_held", ir1[2], 0);
    end
    applyStimulus(3'b111, dcS, dcS, s65, 1'b1);   tick();
    applyStimulus(3'b111, eobS, eobS, s65, 1'b1); tick();
    n2 = 0; seenPop = 1'b0; gotReady = 1'b0;
    for (int k = 0; k < 30 && !gotReady; k++) begin
      applyStimulus(3'b100, '0, '0, s65, 1'b1); tick();
      if (o1_valid && o1_chan == 2'd2) begin
        n2++;
        if (!seenPop) begin
          seenPop = 1'b1;
          checkVal("t4_ready_after_pop", ir1[2], 1);
        end
      end
      gotReady = ir1[2];
    end
    checkVal("t4_ready_returned", gotReady, 1);
    applyStimulus(3'b100, '0, '0, s65, 1'b1); tick();
    if (o1_valid && o1_chan == 2'd2) n2++;
    applyStimulus(3'b000, '0, '0, '0, 1'b1);
    for (int k = 0; k < 75; k++) begin
      tick();
      if (o1_valid && o1_chan == 2'd2) n2++;
    end
    checkVal("t4_ch2_count", n2, 65);

    // Reset in the middle of a luma block.
    doReset();
    outs = 0;
    for (int i = 0; i < 10 && outs < 3; i++) begin
      applyStimulus(3'b001, mkSym(9'(i + 1), 4'd2, 4'(i), 1'b0, i == 9), '0, '0, 1'b1);
      tick();
      if (o1_valid) outs++;
    end
    checkVal("t5_outs", outs, 3);
    doReset();
    checkReset("t5_reset");
    applyStimulus(3'b001, dcS, '0, '0, 1'b1);  tick();
    applyStimulus(3'b001, eobS, '0, '0, 1'b1); tick();
    checkVal("t5_fresh", {o1_valid, o1_chan, o1_isdc, o1_vli}, {1'b1, 2'd0, 1'b1, 9'd5});
    applyStimulus(3'b000, '0, '0, '0, 1'b1);
    tick(); tick();

    // Randomised traffic against the model.
    doReset();
    for (int i = 0; i < 1000; i++) begin
      for (int c = 0; c < 3; c++) rs[c] = sym_t'($urandom);
      applyStimulus(3'($urandom), rs[0], rs[1], rs[2], $urandom_range(0, 9) < 7);
      tick();
    end
    applyStimulus(3'b000, '0, '0, '0, 1'b1);

    // Single-channel one-symbol MCUs push mcu_count through its wrap.
    doReset();
    w_valid[0] = 1'b1;
    for (int k = 0; k <= 65536; k++) begin
      tick();
      if (k == 0 || k == 1 || k == 65535 || k == 65536)
        checkVal($sformatf("t6_mcu_%0d", k), w_mcu, 64'(k % 65536));
    end
    w_valid[0] = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jpeg_mcu_interleaver.md
Name: jpeg_mcu_interleaver

Overview:
- Parametrised successor stage placed after the per-channel entropy coders of the JPEG encode path.
- Buffers each colour channel's entropy symbol stream in its own FIFO.
- Merges all channels into one symbol stream in MCU order, with selectable chroma subsampling (4:4:4 / 4:2:2 / 4:2:0 via luma blocks per MCU).
- Feeds the downstream Huffman/bit-packer over a valid/ready handshake.

Parameters:
- CHANNELS, 3: number of colour channels; channel 0 is luma.
- VLI_WIDTH, 9: width of VLI amplitude field (DATA_WIDTH-1).
- FIFO_DEPTH, 64: symbols per channel FIFO; power of two, >=4.
- Y_BLOCKS, 1: luma blocks per MCU. Legal values: 1 (4:4:4), 2 (4:2:2), 4 (4:2:0).
- CW, $clog2(CHANNELS) min 1: channel-id width.

Ports:
- clk  in  1  Single clock.
- rst_n  in  1  Reset; synchronous, active-high (codebase port name retained).
- in_vli[CHANNELS]  in  VLI_WIDTH  Symbol amplitude bits.
- in_size[CHANNELS]  in  4  VLI bit length (0..11).
- in_run[CHANNELS]  in  4  Zero-run preceding the coefficient (zeroNub).
- in_isDC[CHANNELS]  in  1  Symbol is the block's DC.
- in_eob[CHANNELS]  in  1  Last symbol of the block.
- in_valid[CHANNELS]  in  1  Symbol present.
- in_ready[CHANNELS]  out  1  FIFO can accept.
- out_vli  out  VLI_WIDTH  Merged symbol amplitude.
- out_size  out  4  Merged symbol VLI length.
- out_run  out  4  Merged symbol zero-run.
- out_isDC  out  1  Merged symbol is DC.
- out_eob  out  1  Merged symbol is last of its block.
- out_chan  out  CW  Source channel of the output symbol.
- out_valid  out  1  Output symbol valid.
- out_ready  in  1  Downstream accepts.
- mcu_count  out  16  Completed MCUs, wraps at 65536.
- busy  out  1  Any FIFO non-empty or out_valid high.

Behaviour:
- Reset (rst_n=1 at an edge):
  - All FIFOs empty; in_ready all 1.
  - out_valid=0; all out_* data fields=0; out_chan=0.
  - mcu_count=0; busy=0.
  - Scheduler set to channel 0, block index 0.
  - Applies mid-block too: partial blocks are discarded, no flush.
- Input side:
  - in_ready[c] = !full[c], combinational from occupancy only.
  - A push when full is never accepted, even if the same cycle pops that FIFO.
  - Write occurs on in_valid[c] & in_ready[c].
- FIFO:
  - Occupancy counter 0..FIFO_DEPTH; read/write pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
- Scheduler state (cur_chan, blk_idx):
  - MCU order: channel 0 for Y_BLOCKS blocks, then channels 1..CHANNELS-1 one block each, then wrap to channel 0.
  - Only FIFO[cur_chan] is popped; other channels are never skipped to, even if non-empty. Strict order.
- Output register:
  - Loads when (!out_valid | out_ready) and FIFO[cur_chan] is non-empty.
  - If FIFO[cur_chan] is empty under that condition, out_valid drops to 0 (bubble).
  - While out_valid & !out_ready, all out_* fields hold stable.
- Latency: a symbol written at edge k into an empty current-channel FIFO, with the output free, appears with out_valid=1 after edge k+1.
- Block advance: when a symbol with in_eob=1 is loaded into the output register, the scheduler advances on that same edge:
  - cur_chan=0 and blk_idx<Y_BLOCKS-1: blk_idx++.
  - Otherwise: cur_chan++ and blk_idx=0.
  - From cur_chan=CHANNELS-1: wrap to cur_chan=0 and increment mcu_count.
- The next channel's first symbol may load on the following edge, giving back-to-back output with no bubble if data is present.
- Symbol fields pass through unmodified; no arithmetic on the VLI.

Test Plan:
1. Y_BLOCKS=1; each channel pushes DC(size 3, vli 5) then EOB in the same cycles; out_ready=1 -> out_chan sequence 0,0,1,1,2,2 on consecutive cycles, eob on the 2nd/4th/6th, mcu_count=1.
2. Y_BLOCKS=4; fill ch1 and ch2 with one block each first, then ch0 with four 2-symbol blocks -> no output until ch0 data arrives; out_chan 0×8, 1×2, 2×2; mcu_count=1.
3. Backpressure: out_ready=0 for 5 cycles while out_valid=1 (run=3, vli=0x1A4) -> out_* stable for all 5 cycles; no symbol lost or duplicated after release.
4. Full: scheduler waits on empty ch0 while 64 non-EOB symbols are pushed to ch2 -> in_ready[2]=0 after the 64th write; a 65th held valid is not accepted; in_ready[2] returns to 1 one cycle after ch2 pops.
5. Reset mid-block: assert rst_n for one edge after 3 of 10 ch0 symbols are output -> next cycle out_valid=0, mcu_count=0, in_ready all 1, busy=0; a fresh block then begins on ch0.
6. Wrap: 65536 minimal MCUs (DC+EOB each) -> mcu_count returns to 0.
